// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter_pkg
//  Description : Shared types and constants for the register-file write
//                arbiter: default data/index widths, the queued writeback
//                entry layout and the hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Register r0 is never written.
    localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

    // One queued long-latency result. kill marks an entry superseded by a
    // younger ALU write to the same register; it is popped but not written.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] dest;
        logic [RF_DATA_W-1:0] val;
        logic                 kill;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_fifo
//  Description : Small circular FIFO holding long-latency writeback results
//                that lost arbitration. Each live entry compares its dest
//                with kill_dest and sets its kill bit when kill_en is high.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                push/push_entry - enqueue (ignored when full)
//                pop             - dequeue head (ignored when empty)
//                kill_en/kill_dest - mark live entries with matching dest
//                head, empty     - current head entry and empty flag
//                count_next      - occupancy after this cycle's push/pop
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [RF_ADDR_W-1:0]       kill_dest,
    output wb_entry_t                  head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_kill_hit;

    always_comb begin
        empty      = (r_count == '0);
        w_full     = (r_count == CNT_W'(DEPTH));
        w_push     = push && !w_full;
        w_pop      = pop && !empty;
        count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        head       = r_mem[r_rd_ptr];
    end

    // An entry is live when its distance from the read pointer (modulo
    // DEPTH) is below the occupancy; stale slots are never marked.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
            logic [PTR_W-1:0] w_offset;
            assign w_offset       = PTR_W'(gi) - r_rd_ptr;
            assign w_kill_hit[gi] = kill_en
                                 && ({1'b0, w_offset} < r_count)
                                 && (r_mem[gi].dest == kill_dest);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill_hit[i]) begin
                    r_mem[i].kill <= 1'b1;
                end
            end
            // The write slot is never live when a push is allowed, so the
            // incoming entry (with its own kill bit) cannot collide with
            // the kill updates above.
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Drives the register-file write port from two sources: the
//                in-order ALU writeback (highest priority, never stalled)
//                and long-latency results arriving over valid/ready, which
//                queue in rf_wb_fifo when they lose arbitration. An ALU
//                write kills any queued or same-cycle long-latency result
//                for the same register, since the ALU result is younger.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                alu_valid/alu_dest/alu_val - ALU writeback input
//                ll_valid/ll_ready/ll_dest/ll_val - long-latency handshake
//                rf_write_enable/rf_dest/rf_destVal - register file port
//                perf_ll_stall/perf_kill    - counters (RF_WRITE_ARB_PERF_EN)
//  Options     : define RF_WRITE_ARB_PERF_EN to add the two perf counters.
//  Note        : the queued entry type uses the package widths; keep DATA_W
//                and ADDR_W equal to RF_DATA_W / RF_ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_val,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] ll_dest,
    input  logic [DATA_W-1:0] ll_val,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_destVal
`ifdef RF_WRITE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ll_stall,
    output logic [31:0]       perf_kill
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              r_ll_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_dest;
    logic [DATA_W-1:0] r_val;

    logic              w_alu_sel;
    logic              w_push;
    logic              w_pop;
    logic              w_head_write;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_count_next;
    wb_entry_t         w_push_entry;
    wb_entry_t         w_head;

    always_comb begin
        // ALU writes to r0 are dropped and leave the slot to the FIFO.
        w_alu_sel    = alu_valid && (alu_dest != REG_ZERO);
        // ll_ready is registered from the occupancy, so it is only high
        // when the FIFO has room this cycle.
        w_push       = ll_valid && r_ll_ready;
        w_pop        = !w_alu_sel && !w_fifo_empty;
        w_head_write = w_pop && !w_head.kill && (w_head.dest != REG_ZERO);

        w_push_entry.dest = ll_dest;
        w_push_entry.val  = ll_val;
        // An entry arriving alongside a same-dest ALU write is already stale.
        w_push_entry.kill = w_alu_sel && (ll_dest == alu_dest);
    end

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .kill_en    (w_alu_sel),
        .kill_dest  (alu_dest),
        .head       (w_head),
        .empty      (w_fifo_empty),
        .count_next (w_count_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ll_ready <= 1'b0;
            r_we       <= 1'b0;
            r_dest     <= '0;
            r_val      <= '0;
        end else begin
            r_ll_ready <= (w_count_next < CNT_W'(DEPTH));
            if (w_alu_sel) begin
                r_we   <= 1'b1;
                r_dest <= alu_dest;
                r_val  <= alu_val;
            end else if (w_head_write) begin
                r_we   <= 1'b1;
                r_dest <= w_head.dest;
                r_val  <= w_head.val;
            end else begin
                // Dest/value hold their last values when nothing is written.
                r_we   <= 1'b0;
            end
        end
    end

    assign ll_ready        = r_ll_ready;
    assign rf_write_enable = r_we;
    assign rf_dest         = r_dest;
    assign rf_destVal      = r_val;

`ifdef RF_WRITE_ARB_PERF_EN
    logic [31:0] r_perf_ll_stall;
    logic [31:0] r_perf_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ll_stall <= '0;
            r_perf_kill     <= '0;
        end else begin
            if (ll_valid && !r_ll_ready) begin
                r_perf_ll_stall <= r_perf_ll_stall + 32'd1;
            end
            if (w_pop && w_head.kill) begin
                r_perf_kill <= r_perf_kill + 32'd1;
            end
        end
    end

    assign perf_ll_stall = r_perf_ll_stall;
    assign perf_kill     = r_perf_kill;
`endif

endmodule
`default_nettype wire
